// File: rtl/fpu_pkg.sv
// Shared constants, operand classification helpers and stage-1 bookkeeping
// types for the single-precision add issue path.
package fpu_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_NADD = 2'b10;
   localparam logic [1:0] OP_NSUB = 2'b11;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] PINF = 32'h7F80_0000;

   // Special-case summary captured next to the operands in stage 1.
   typedef struct packed {
      logic nan_in;
      logic inf_a;
      logic inf_b;
      logic sa;
      logic sb;
   } s1_cls_t;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
module fp_classify (
   input  logic [31:0] x,
   output logic        sign,
   output logic        is_zero,
   output logic        is_inf,
   output logic        is_nan
);

   assign sign    = x[31];
   assign is_zero = (x[30:0] == 31'h0);
   assign is_inf  = fpu_pkg::is_inf(x);
   assign is_nan  = fpu_pkg::is_nan(x);

endmodule

// File: rtl/fadd_issue.sv
// Two-stage valid/ready wrapper around the external combinational fadd core,
// with Inf/NaN result override and sticky {nv, ovf} status flags.
module fadd_issue
   import fpu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_x1,
   input  logic [31:0]      in_x2,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      fa_x1,
   output logic [31:0]      fa_x2,
   input  logic [31:0]      fa_y,
   input  logic             fa_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_y,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_ovf,
   output logic             out_nv,
   input  logic             clr_flags,
   output logic [1:0]       flags
);

   logic             adv1;
   logic             adv2;
   logic             in_xfer;
   logic             out_xfer;
   logic [31:0]      x2_eff;

   logic             a_sign;
   logic             a_inf;
   logic             a_nan;
   logic             b_sign;
   logic             b_inf;
   logic             b_nan;
   logic             unused_zero_a;
   logic             unused_zero_b;

   s1_cls_t          in_cls;
   logic             s1_valid;
   logic             s1_neg;
   logic [TAG_W-1:0] s1_tag;
   s1_cls_t          s1_cls;

   logic [31:0]      res_y;
   logic             res_ovf;
   logic             res_nv;

   // Handshake: each stage may load whenever the stage after it frees up.
   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // Subtraction is folded into operand B's sign before it reaches fadd.
   assign x2_eff = {in_x2[31] ^ in_op[0], in_x2[30:0]};

   fp_classify u_cls_a (
      .x       (in_x1),
      .sign    (a_sign),
      .is_zero (unused_zero_a),
      .is_inf  (a_inf),
      .is_nan  (a_nan)
   );

   fp_classify u_cls_b (
      .x       (x2_eff),
      .sign    (b_sign),
      .is_zero (unused_zero_b),
      .is_inf  (b_inf),
      .is_nan  (b_nan)
   );

   assign in_cls = '{
      nan_in: a_nan || b_nan,
      inf_a:  a_inf,
      inf_b:  b_inf,
      sa:     a_sign,
      sb:     b_sign
   };

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         fa_x1    <= 32'h0;
         fa_x2    <= 32'h0;
         s1_neg   <= 1'b0;
         s1_tag   <= '0;
         s1_cls   <= '0;
      end else if (in_xfer) begin
         s1_valid <= 1'b1;
         fa_x1    <= in_x1;
         fa_x2    <= x2_eff;
         s1_neg   <= in_op[1];
         s1_tag   <= in_tag;
         s1_cls   <= in_cls;
      end else if (adv1) begin
         s1_valid <= 1'b0;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      res_y   = fa_y;
      res_ovf = fa_ovf;
      res_nv  = 1'b0;
      if (s1_cls.nan_in || (s1_cls.inf_a && s1_cls.inf_b && (s1_cls.sa != s1_cls.sb))) begin
         res_y   = QNAN;
         res_ovf = 1'b0;
         res_nv  = 1'b1;
      end else if (s1_cls.inf_a || s1_cls.inf_b) begin
         res_y   = {(s1_cls.inf_a ? s1_cls.sa : s1_cls.sb), PINF[30:0]};
         res_ovf = 1'b0;
      end
      // The canonical quiet NaN keeps its sign under result negation.
      if (s1_neg && !res_nv) begin
         res_y[31] = ~res_y[31];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_y     <= 32'h0;
         out_tag   <= '0;
         out_ovf   <= 1'b0;
         out_nv    <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_y   <= res_y;
            out_tag <= s1_tag;
            out_ovf <= res_ovf;
            out_nv  <= res_nv;
         end
      end
   end

   // A clear coinciding with a transfer still records the departing result.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         flags <= 2'b00;
      end else begin
         flags <= (clr_flags ? 2'b00 : flags) | (out_xfer ? {out_nv, out_ovf} : 2'b00);
      end
   end

   property p_out_hold;
      @(posedge clk) disable iff (!rstn)
         (out_valid && !out_ready) |=> (out_valid && $stable(out_y) && $stable(out_tag)
                                         && $stable(out_ovf) && $stable(out_nv));
   endproperty
   a_out_hold: assert property (p_out_hold);

   property p_s1_hold;
      @(posedge clk) disable iff (!rstn)
         (s1_valid && !adv1) |=> (s1_valid && $stable(fa_x1) && $stable(fa_x2) && $stable(s1_tag));
   endproperty
   a_s1_hold: assert property (p_s1_hold);

endmodule

// File: doc/fadd_issue.md
Name: fadd_issue

Overview:
- Two-stage valid/ready pipeline wrapped around the combinational fadd core.
- Accepts operand pairs with an opcode and a tag, pre-conditions the operands, and drives fadd's x1/x2 from a registered stage.
- Captures fadd's y/ovf into an output register, overriding the result for Inf/NaN operands, which fadd does not handle.
- Maintains sticky exception flags for the FPU status path.

Parameters:
- TAG_W, 4, width of the caller tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept this cycle
- in_op  in  2  op[0]=negate x2 (sub), op[1]=negate result
- in_x1  in  32  operand A, IEEE-754 single
- in_x2  in  32  operand B, IEEE-754 single
- in_tag  in  TAG_W  caller tag
- fa_x1  out  32  to fadd x1 (stage-1 register)
- fa_x2  out  32  to fadd x2 (stage-1 register)
- fa_y  in  32  from fadd y
- fa_ovf  in  1  from fadd ovf
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_y  out  32  result
- out_tag  out  TAG_W  tag of result
- out_ovf  out  1  overflow for this result
- out_nv  out  1  invalid operation for this result
- clr_flags  in  1  clear sticky flags
- flags  out  2  sticky {nv, ovf}

Behaviour:
- Reset (async, rstn=0):
  - s1_valid, out_valid, flags, out_ovf, out_nv = 0.
  - out_y, fa_x1, fa_x2 = 32'h0; out_tag = 0.
  - Recovery is synchronous to clk.
- Handshake:
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational; no registered ready).
  - Transfer on in_valid & in_ready; out transfer on out_valid & out_ready.
- Stage 1, on in transfer:
  - fa_x1 = in_x1; fa_x2 = {in_x2[31]^in_op[0], in_x2[30:0]}.
  - Latch op[1], tag, and special-case classification:
    - nan_in = either operand exp==255 and mant!=0.
    - inf_a, inf_b = exp==255 and mant==0.
    - sA, sB = effective signs after op[0].
  - s1_valid = 1.
  - If adv1 and no in transfer: s1_valid = 0.
- Stage 2, on adv2 & s1_valid:
  - If nan_in, or (inf_a & inf_b & sA!=sB): out_y = 32'h7FC00000, out_nv = 1, out_ovf = 0.
  - Else if inf_a or inf_b: out_y = infinity carrying the sign of the infinite operand, nv = 0, ovf = 0.
  - Else: out_y = fa_y, out_ovf = fa_ovf, out_nv = 0.
  - If op[1] and the result is not NaN, invert out_y[31]. -0 and +0 are both produced legitimately.
  - out_valid = 1.
  - On adv2 & !s1_valid: out_valid = 0.
- Latency:
  - Accepted at edge k gives out_valid high after edge k+1 when unstalled.
  - Throughput is 1/cycle.
- Backpressure:
  - out_valid & !out_ready holds out_* stable.
  - Stage 1 holds while full; in_ready = 0 only when both stages are full and out_ready = 0.
  - No operation is lost or duplicated.
- Flags:
  - flags |= {out_nv, out_ovf} on each out transfer.
  - clr_flags clears flags. If it coincides with a transfer, the new result's bits are still set (set wins).
- fa_x1/fa_x2 hold their last value when stage 1 is empty; they have no functional meaning then.
- Reset mid-operation discards both stages; no partial output appears after release.

Decomposition:
- Package fpu_pkg:
  - op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_NADD=2'b10, OP_NSUB=2'b11.
  - QNAN=32'h7FC00000, PINF=32'h7F800000.
  - Classification function is_nan/is_inf on 32-bit.
- One natural sub-module: fp_classify (combinational; outputs sign, is_zero, is_inf, is_nan).
- fadd is external; it is instantiated by the parent, not inside this block.

Test Plan:
- 3F800000 + 40000000, op=00, out_ready=1 -> out_y=40400000 two edges later, ovf=0, nv=0, tag echoed.
- 3F800000, 3F800000, op=01 -> out_y=00000000. Same with op=11 -> out_y=80000000.
- 7F800000, 7F800000, op=01 -> out_y=7FC00000, out_nv=1, flags=2'b10. Then clr_flags -> flags=0.
- 7F7FFFFF + 7F7FFFFF, op=00 -> out_y=7F800000, out_ovf=1, flags[0]=1.
- Stream tags 0..7 with out_ready low for 5 cycles mid-stream:
  - in_ready drops once two are held.
  - All 8 results appear in order with no loss or duplication.
  - out_* stable while stalled.
- Assert rstn=0 with both stages full -> out_valid=0 immediately. After release, no stale result appears; a new op completes normally.
